femto_tickgen: RTL and testbench

Fractional tick generator and one-shot timer clocked by the internal clock that the PLL produces. It divides the high-frequency core clock down to an exact average tick rate using a phase accumulator, so the result has no cumulative drift even when the ratio is non-integer. Peripherals such as UART bit timing, millisecond timers and LED blinkers use these ticks as clock enables. Instantiated next to the PLL and fed from its `clk` output; all consumers stay in the single core clock domain.

---
 rtl/femto_tickgen.sv | 141 ++++++++++++++
 tb/tb_femto_tickgen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/femto_tickgen.sv
// femto_tickgen: fractional tick generator with a one-shot tick-based timer.
// A phase accumulator adds TICK_HZ per enabled cycle and wraps at FREQ_HZ.
// This gives an exact long-term average of TICK_HZ ticks per second of core clock.
// The timer counts registered ticks down from a loaded value and pulses done on expiry.
module femto_tickgen #(
  parameter int unsigned FREQ_MHZ = 60,
  parameter int unsigned TICK_HZ  = 1_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        clr,
  output logic        tick,
  output logic [31:0] tick_count,
  input  logic        timer_load,
  input  logic [15:0] timer_value,
  output logic        timer_busy,
  output logic        timer_done
);

  localparam int unsigned FREQ_HZ = FREQ_MHZ * 1_000_000;
  // One spare bit so acc + TICK_HZ never overflows before the wrap compare.
  localparam int unsigned ACC_W   = $clog2(FREQ_HZ) + 1;
  localparam logic [ACC_W-1:0] FREQ_C = ACC_W'(FREQ_HZ);
  localparam logic [ACC_W-1:0] INC_C  = ACC_W'(TICK_HZ);

  // A rate above FREQ_HZ/2 could produce back-to-back ticks, which consumers do not expect.
  if (TICK_HZ == 0 || TICK_HZ > FREQ_HZ / 2) begin : g_bad_cfg
    $error("femto_tickgen: TICK_HZ must be in 1 .. FREQ_HZ/2");
  end

  // ---------------------------------------------------------------------------
  // Phase accumulator
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             tick_q, tick_d;

  // Next accumulator phase and tick decision; clear wins over enable.
  always_comb begin
    sum    = acc_q + INC_C;
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      if (sum >= FREQ_C) begin
        acc_d  = sum - FREQ_C;
        tick_d = 1'b1;
      end else begin
        acc_d  = sum;
      end
    end
  end

  // Accumulator and registered tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running tick counter (counts the registered tick, wraps naturally)
  // ---------------------------------------------------------------------------
  logic [31:0] tick_count_q;

  // Count one per registered tick; untouched by clr.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_count_q <= '0;
    end else if (tick_q) begin
      tick_count_q <= tick_count_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // One-shot timer
  // ---------------------------------------------------------------------------
  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_t;

  timer_state_t state_q, state_d;
  logic [15:0]  remaining_q, remaining_d;
  logic         done_q, done_d;

  // Timer next state: load (restart) beats tick, so a tick coincident with a load is dropped.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    if (timer_load) begin
      if (timer_value == 16'd0) begin
        state_d     = T_IDLE;
        remaining_d = 16'd0;
        done_d      = 1'b1;
      end else begin
        state_d     = T_RUN;
        remaining_d = timer_value;
      end
    end else if (state_q == T_RUN && tick_q) begin
      if (remaining_q == 16'd1) begin
        state_d     = T_IDLE;
        remaining_d = 16'd0;
        done_d      = 1'b1;
      end else begin
        remaining_d = remaining_q - 16'd1;
      end
    end
  end

  // Timer state registers; reset aborts a running timer without a done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= T_IDLE;
      remaining_q <= 16'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign tick       = tick_q;
  assign tick_count = tick_count_q;
  assign timer_busy = (state_q == T_RUN);
  assign timer_done = done_q;

  // After a wrap acc < TICK_HZ <= FREQ_HZ/2, so the very next sum cannot reach FREQ_HZ.
  a_tick_isolated : assert property (@(posedge clk) disable iff (!resetn) tick_q |=> !tick_q);

  // Done always coincides with the timer having returned to idle.
  a_done_idle : assert property (@(posedge clk) disable iff (!resetn) done_q |-> (state_q == T_IDLE));

endmodule

// File: tb/tb_femto_tickgen.sv
// Bench for femto_tickgen: an integer-ratio instance (1 MHz / 250 kHz) and a
// fractional-ratio instance (1 MHz / 300 kHz) share clock, reset, en and clr.
// Stimulus pushes hand-computed event cycles into queues; monitors pop and compare.
module tb_femto_tickgen;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        timer_load = 1'b0;
  logic [15:0] timer_value = 16'd0;
  logic        tick;
  logic [31:0] tick_count;
  logic        timer_busy;
  logic        timer_done;

  logic        load_f = 1'b0;
  logic [15:0] value_f = 16'd0;
  logic        tick_f;
  logic [31:0] count_f;
  logic        busy_f;
  logic        done_f;

  femto_tickgen #(.FREQ_MHZ(1), .TICK_HZ(250_000)) dut (
    .clk(clk), .resetn(resetn), .en(en), .clr(clr),
    .tick(tick), .tick_count(tick_count),
    .timer_load(timer_load), .timer_value(timer_value),
    .timer_busy(timer_busy), .timer_done(timer_done)
  );

  femto_tickgen #(.FREQ_MHZ(1), .TICK_HZ(300_000)) dut_f (
    .clk(clk), .resetn(resetn), .en(en), .clr(clr),
    .tick(tick_f), .tick_count(count_f),
    .timer_load(load_f), .timer_value(value_f),
    .timer_busy(busy_f), .timer_done(done_f)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_tick_q[$];
  int exp_frac_q[$];
  int exp_done_q[$];
  bit mon_en  = 1'b0;
  bit fmon_en = 1'b0;
  int last_f  = -1;
  int n_cmp   = 0;
  int n_err   = 0;
  int r;
  int w;
  int frac_off[3] = '{4, 7, 10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (mon_en && tick === 1'b1) begin
      if (exp_tick_q.size() == 0) begin
        check("tick_unexpected_cycle", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_tick_q.pop_front();
        $display("tick      at cycle %0d, expected %0d", cyc, e);
        check("tick_cycle", 32'(cyc), 32'(e));
      end
    end
    if (fmon_en && tick_f === 1'b1) begin
      if (exp_frac_q.size() == 0) begin
        check("frac_tick_unexpected_cycle", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_frac_q.pop_front();
        $display("frac tick at cycle %0d, expected %0d", cyc, e);
        check("frac_tick_cycle", 32'(cyc), 32'(e));
        if (last_f >= 0)
          check("frac_interval_3_or_4", 32'((cyc - last_f == 3) || (cyc - last_f == 4)), 32'd1);
        last_f = cyc;
      end
    end
    if (timer_done === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        check("done_unexpected_cycle", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_done_q.pop_front();
        $display("done      at cycle %0d, expected %0d", cyc, e);
        check("done_cycle", 32'(cyc), 32'(e));
        check("busy_low_at_done", 32'(timer_busy), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_tick_count", tick_count, 32'd0);
    check("rst_busy", 32'(timer_busy), 32'd0);
    check("rst_done", 32'(timer_done), 32'd0);
    check("rst_frac_tick", 32'(tick_f), 32'd0);
    check("rst_frac_busy", 32'(busy_f), 32'd0);

    // Integer and fractional ratios with en high from reset release.
    r = cyc;
    resetn = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 25; k++) exp_tick_q.push_back(r + 4 * k);
    for (int j = 0; j < 10; j++)
      for (int i = 0; i < 3; i++) exp_frac_q.push_back(r + 10 * j + frac_off[i]);
    mon_en = 1'b1;
    fmon_en = 1'b1;
    wait_until(r + 101);
    check("int_count_after_100", tick_count, 32'd25);
    check("frac_count_after_100", count_f, 32'd30);
    fmon_en = 1'b0;
    check("frac_ticks_pending", 32'(exp_frac_q.size()), 32'd0);
    check("int_ticks_pending", 32'(exp_tick_q.size()), 32'd0);

    // Freeze for 7 cycles: acc holds 250k, so 3 enabled cycles finish the tick.
    en = 1'b0;
    exp_tick_q.push_back(r + 111);
    wait_until(r + 108);
    en = 1'b1;
    wait_until(r + 113);
    clr = 1'b1;
    wait_until(r + 114);
    clr = 1'b0;
    check("tick_low_after_clr", 32'(tick), 32'd0);
    for (int k = 0; k <= 14; k++) exp_tick_q.push_back(r + 118 + 4 * k);

    // Timer of 3 ticks.
    wait_until(r + 119);
    timer_load = 1'b1;
    timer_value = 16'd3;
    exp_done_q.push_back(r + 131);
    wait_until(r + 120);
    timer_load = 1'b0;
    check("busy_after_load3", 32'(timer_busy), 32'd1);
    wait_until(r + 130);
    check("busy_on_third_tick", 32'(timer_busy), 32'd1);
    wait_until(r + 131);
    check("busy_fall_with_done", 32'(timer_busy), 32'd0);

    // Zero-length timer.
    wait_until(r + 133);
    timer_load = 1'b1;
    timer_value = 16'd0;
    exp_done_q.push_back(r + 134);
    wait_until(r + 134);
    timer_load = 1'b0;
    check("busy_stays_low_load0", 32'(timer_busy), 32'd0);

    // Reload with 5 on the tick cycle: that tick is dropped.
    wait_until(r + 135);
    timer_load = 1'b1;
    timer_value = 16'd5;
    wait_until(r + 136);
    timer_load = 1'b0;
    check("busy_after_load5", 32'(timer_busy), 32'd1);
    wait_until(r + 142);
    check("tick_at_reload", 32'(tick), 32'd1);
    timer_load = 1'b1;
    timer_value = 16'd5;
    exp_done_q.push_back(r + 163);
    wait_until(r + 143);
    timer_load = 1'b0;
    wait_until(r + 159);
    check("busy_after_reload", 32'(timer_busy), 32'd1);
    wait_until(r + 163);
    check("busy_after_reload_done", 32'(timer_busy), 32'd0);

    // Reset in the middle of a run.
    wait_until(r + 165);
    timer_load = 1'b1;
    timer_value = 16'd4;
    wait_until(r + 166);
    timer_load = 1'b0;
    check("busy_after_load4", 32'(timer_busy), 32'd1);
    wait_until(r + 176);
    check("int_ticks_pending_2", 32'(exp_tick_q.size()), 32'd0);
    mon_en = 1'b0;
    resetn = 1'b0;
    en = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(timer_busy), 32'd0);
    check("midrun_rst_done", 32'(timer_done), 32'd0);
    check("midrun_rst_count", tick_count, 32'd0);
    check("midrun_rst_tick", 32'(tick), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_after_rst_busy", 32'(timer_busy), 32'd0);

    // Counter wrap.
    force dut.tick_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.tick_count_q;
    @(negedge clk);
    w = cyc;
    en = 1'b1;
    wait_until(w + 4);
    check("wrap_tick", 32'(tick), 32'd1);
    check("wrap_preload", tick_count, 32'hFFFF_FFFE);
    wait_until(w + 5);
    check("wrap_max", tick_count, 32'hFFFF_FFFF);
    wait_until(w + 9);
    check("wrap_zero", tick_count, 32'h0000_0000);

    check("done_pending", 32'(exp_done_q.size()), 32'd0);
    check("frac_done_never", 32'(done_f), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
